alu_modport: RTL and testbench

ALU_MODPORT -- requirements
Module: alu_modport

---
 rtl/alu_modport.sv | 94 +++++++++
 tb/tb_alu_modport.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/alu_modport.sv
// Single-stage registered ALU: samples operands and opcode every rising edge,
// result and calculated appear one cycle later; NOP holds the previous result.
module alu_modport #(
    parameter int DATA_W = 8
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic [DATA_W-1:0] input_a,
    input  logic [DATA_W-1:0] input_b,
    input  logic [3:0]        operator,
    output logic              calculated,
    output logic [DATA_W-1:0] result
);

    localparam int SH_W = $clog2(DATA_W);

    localparam logic [3:0] OP_ADD = 4'h0;
    localparam logic [3:0] OP_SUB = 4'h1;
    localparam logic [3:0] OP_MUL = 4'h2;
    localparam logic [3:0] OP_DIV = 4'h3;
    localparam logic [3:0] OP_MOD = 4'h4;
    localparam logic [3:0] OP_AND = 4'h5;
    localparam logic [3:0] OP_OR  = 4'h6;
    localparam logic [3:0] OP_XOR = 4'h7;
    localparam logic [3:0] OP_NOT = 4'h8;
    localparam logic [3:0] OP_SHL = 4'h9;
    localparam logic [3:0] OP_SHR = 4'hA;
    localparam logic [3:0] OP_ROL = 4'hB;
    localparam logic [3:0] OP_ROR = 4'hC;
    localparam logic [3:0] OP_EQ  = 4'hD;
    localparam logic [3:0] OP_GT  = 4'hE;
    localparam logic [3:0] OP_NOP = 4'hF;

    function automatic logic [DATA_W-1:0] alu_eval(
        input logic [DATA_W-1:0] a,
        input logic [DATA_W-1:0] b,
        input logic [3:0]        op
    );
        logic [DATA_W-1:0]   y;
        logic [2*DATA_W-1:0] prod;
        logic [2*DATA_W-1:0] dbl;
        logic [SH_W-1:0]     sh;
        y    = '0;
        sh   = b[SH_W-1:0];
        prod = {{DATA_W{1'b0}}, a} * {{DATA_W{1'b0}}, b};
        dbl  = '0;
        case (op)
            OP_ADD: y = a + b;
            OP_SUB: y = a - b;
            OP_MUL: y = prod[DATA_W-1:0];
            // Divide-by-zero yields all-ones for DIV and passes a through for MOD
            OP_DIV: y = (b == '0) ? '1 : a / b;
            OP_MOD: y = (b == '0) ? a : a % b;
            OP_AND: y = a & b;
            OP_OR:  y = a | b;
            OP_XOR: y = a ^ b;
            OP_NOT: y = ~a;
            OP_SHL: y = a << sh;
            OP_SHR: y = a >> sh;
            OP_ROL: begin
                dbl = {a, a} << sh;
                y   = dbl[2*DATA_W-1:DATA_W];
            end
            OP_ROR: begin
                dbl = {a, a} >> sh;
                y   = dbl[DATA_W-1:0];
            end
            OP_EQ:  y[0] = (a == b);
            OP_GT:  y[0] = (a > b);
            default: y = '0;
        endcase
        return y;
    endfunction

    logic [DATA_W-1:0] result_p1;
    logic              vld_p1;

    // Stage p0 -> p1: sample inputs, register outcome
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            result_p1 <= '0;
            vld_p1    <= 1'b0;
        end else begin
            vld_p1 <= (operator != OP_NOP);
            if (operator != OP_NOP) begin
                result_p1 <= alu_eval(input_a, input_b, operator);
            end
        end
    end

    assign result     = result_p1;
    assign calculated = vld_p1;

endmodule

// File: tb/tb_alu_modport.sv
// Bench for alu_modport: directed vector table, reset corner cases, and
// random operations checked against an integer-arithmetic reference model.
module tb_alu_modport;

    logic       clock;
    logic       reset_n;
    logic [7:0] input_a;
    logic [7:0] input_b;
    logic [3:0] operator;
    logic       calculated;
    logic [7:0] result;

    int n_vec;
    int n_bad;
    int prev_res;

    typedef struct {
        logic [3:0] op;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] exp_res;
        logic       exp_calc;
    } vec_t;

    vec_t vecs [24];

    alu_modport #(.DATA_W(8)) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .input_a    (input_a),
        .input_b    (input_b),
        .operator   (operator),
        .calculated (calculated),
        .result     (result)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string name, input int actual, input int expected);
        n_vec++;
        if (actual !== expected) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    // Reference model: returns {calculated, result} from plain integer arithmetic
    function automatic int ref_alu(input int op, input int a, input int b, input int prev);
        int s;
        int r;
        s = b % 8;
        case (op)
            0:  r = (a + b) % 256;
            1:  r = (a - b + 256) % 256;
            2:  r = (a * b) % 256;
            3:  r = (b == 0) ? 255 : a / b;
            4:  r = (b == 0) ? a : a % b;
            5:  r = a & b;
            6:  r = a | b;
            7:  r = a ^ b;
            8:  r = 255 - a;
            9:  r = (a * (1 << s)) % 256;
            10: r = a / (1 << s);
            11: r = (a * (1 << s) + a / (1 << (8 - s))) % 256;
            12: r = (a / (1 << s) + a * (1 << (8 - s))) % 256;
            13: r = (a == b) ? 1 : 0;
            14: r = (a > b) ? 1 : 0;
            default: return prev;
        endcase
        return 256 + r;
    endfunction

    task automatic apply(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
        operator = op;
        input_a  = a;
        input_b  = b;
        @(posedge clock);
        #1;
    endtask

    initial begin
        n_vec    = 0;
        n_bad    = 0;
        prev_res = 0;

        vecs[0]  = '{4'h0, 8'hF0, 8'h20, 8'h10, 1'b1};
        vecs[1]  = '{4'h1, 8'h05, 8'h07, 8'hFE, 1'b1};
        vecs[2]  = '{4'h2, 8'h10, 8'h11, 8'h10, 1'b1};
        vecs[3]  = '{4'h3, 8'h64, 8'h07, 8'h0E, 1'b1};
        vecs[4]  = '{4'h4, 8'h64, 8'h07, 8'h02, 1'b1};
        vecs[5]  = '{4'h3, 8'h2A, 8'h00, 8'hFF, 1'b1};
        vecs[6]  = '{4'h4, 8'h2A, 8'h00, 8'h2A, 1'b1};
        vecs[7]  = '{4'hB, 8'h81, 8'h09, 8'h03, 1'b1};
        vecs[8]  = '{4'hA, 8'h80, 8'h03, 8'h10, 1'b1};
        vecs[9]  = '{4'hE, 8'h80, 8'h7F, 8'h01, 1'b1};
        vecs[10] = '{4'hD, 8'h12, 8'h34, 8'h00, 1'b1};
        vecs[11] = '{4'h0, 8'h01, 8'h01, 8'h02, 1'b1};
        vecs[12] = '{4'hF, 8'h55, 8'h66, 8'h02, 1'b0};
        vecs[13] = '{4'hF, 8'hAA, 8'h00, 8'h02, 1'b0};
        vecs[14] = '{4'hD, 8'h5A, 8'h5A, 8'h01, 1'b1};
        vecs[15] = '{4'h9, 8'h81, 8'h0B, 8'h08, 1'b1};
        vecs[16] = '{4'hC, 8'h81, 8'h01, 8'hC0, 1'b1};
        vecs[17] = '{4'h8, 8'h0F, 8'h99, 8'hF0, 1'b1};
        vecs[18] = '{4'h5, 8'hF0, 8'h3C, 8'h30, 1'b1};
        vecs[19] = '{4'h6, 8'hF0, 8'h0F, 8'hFF, 1'b1};
        vecs[20] = '{4'h7, 8'hFF, 8'h0F, 8'hF0, 1'b1};
        vecs[21] = '{4'hA, 8'h80, 8'h08, 8'h80, 1'b1};
        vecs[22] = '{4'hE, 8'h7F, 8'h80, 8'h00, 1'b1};
        vecs[23] = '{4'h1, 8'h00, 8'h01, 8'hFF, 1'b1};

        // Reset held with active stimulus: outputs must stay cleared
        reset_n  = 1'b0;
        operator = 4'h0;
        input_a  = 8'h11;
        input_b  = 8'h22;
        #2;
        check("reset_result", result, 0);
        check("reset_calc", calculated, 0);
        repeat (3) @(posedge clock);
        #1;
        check("reset_hold_result", result, 0);
        check("reset_hold_calc", calculated, 0);

        @(negedge clock);
        reset_n = 1'b1;

        foreach (vecs[i]) begin
            apply(vecs[i].op, vecs[i].a, vecs[i].b);
            check($sformatf("vec%0d_result", i), result, vecs[i].exp_res);
            check($sformatf("vec%0d_calc", i), calculated, vecs[i].exp_calc);
        end

        // Mid-stream asynchronous reset between edges
        apply(4'h2, 8'h03, 8'h05);
        check("pre_rst_result", result, 8'h0F);
        operator = 4'h0;
        input_a  = 8'h10;
        input_b  = 8'h10;
        #2;
        reset_n = 1'b0;
        #1;
        check("async_rst_result", result, 0);
        check("async_rst_calc", calculated, 0);
        @(posedge clock);
        #1;
        check("rst_edge_result", result, 0);
        check("rst_edge_calc", calculated, 0);
        @(negedge clock);
        reset_n = 1'b1;
        apply(4'h0, 8'h10, 8'h10);
        check("post_rst_result", result, 8'h20);
        check("post_rst_calc", calculated, 1);
        prev_res = 8'h20;

        // Random back-to-back operations against the reference model
        for (int k = 0; k < 400; k++) begin
            int op;
            int a;
            int b;
            int exp;
            op = $urandom_range(0, 15);
            a  = $urandom_range(0, 255);
            b  = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(0, 255);
            exp = ref_alu(op, a, b, prev_res);
            apply(op[3:0], a[7:0], b[7:0]);
            check($sformatf("rnd%0d_op%0h_result", k, op), result, exp % 256);
            check($sformatf("rnd%0d_op%0h_calc", k, op), calculated, exp / 256);
            prev_res = exp % 256;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
